// File: rtl/dma_line_responder.sv
// dma_line_responder: responder side of the accelerator DMA interface.
// Moves one LINE_W-bit line per request over a single-outstanding 32-bit
// word port. Reads return the DATA_W line MSBs; writes send the payload
// MSB-first followed by zero padding.
// Optional feature: define DMA_TIMEOUT_EN to abort a beat whose mem_ack
// has not arrived within TIMEOUT_CYCLES cycles.
module dma_line_responder #(
  parameter int DATA_W         = 381,
  parameter int LINE_W         = 1024,
  parameter int BEATS          = LINE_W / 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              dma_rx_start,
  input  logic [31:0]       dma_rx_address,
  output logic [DATA_W-1:0] dma_rx_data,
  input  logic              dma_tx_start,
  input  logic [31:0]       dma_tx_address,
  input  logic [DATA_W-1:0] dma_tx_data,
  output logic              dma_done,
  output logic              dma_idle,
  output logic              dma_error,
  output logic              mem_req,
  output logic              mem_we,
  output logic [31:0]       mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_err
);

  localparam int KW = $clog2(BEATS);

  if ((LINE_W % 32) != 0 || BEATS != LINE_W / 32 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
    $error("dma_line_responder: inconsistent LINE_W/BEATS/TIMEOUT_CYCLES");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_WRITE,
    S_CMPL,
    S_ERR,
    S_DONE
  } state_t;

  state_t              r_state;
  state_t              w_state_next;
  logic [KW-1:0]       r_k;
  logic [LINE_W-1:0]   r_line;
  logic [DATA_W-1:0]   r_rx_data;
  logic                r_error;
  logic                r_mem_req;
  logic                r_mem_we;
  logic [31:0]         r_mem_addr;
  logic                w_rx_acc;
  logic                w_tx_acc;
  logic                w_start;
  logic [31:0]         w_start_addr;
  logic                w_aligned;
  logic                w_beat;
  logic                w_last;
  logic                w_timeout;

  // rx has priority when both starts arrive together; starts only count in IDLE
  assign w_rx_acc     = (r_state == S_IDLE) && dma_rx_start;
  assign w_tx_acc     = (r_state == S_IDLE) && !dma_rx_start && dma_tx_start;
  assign w_start      = w_rx_acc || w_tx_acc;
  assign w_start_addr = w_rx_acc ? dma_rx_address : dma_tx_address;
  assign w_aligned    = (w_start_addr[1:0] == 2'b00);
  assign w_beat       = r_mem_req && mem_ack;
  assign w_last       = (r_k == KW'(BEATS - 1));

`ifdef DMA_TIMEOUT_EN
  logic [$clog2(TIMEOUT_CYCLES+1)-1:0] r_wait;

  // Per-beat wait counter, restarted for every new word request
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_wait <= '0;
    end else if (w_start || w_beat || !r_mem_req) begin
      r_wait <= '0;
    end else begin
      r_wait <= r_wait + 1'b1;
    end
  end

  assign w_timeout = r_mem_req && !mem_ack &&
                     (r_wait == ($clog2(TIMEOUT_CYCLES+1))'(TIMEOUT_CYCLES - 1));
`else
  assign w_timeout = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic; CMPL is the one-cycle slot where a finished read line is published
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (w_start) begin
          if (!w_aligned)    w_state_next = S_ERR;
          else if (w_rx_acc) w_state_next = S_READ;
          else               w_state_next = S_WRITE;
        end
      end
      S_READ, S_WRITE: begin
        if (w_beat) begin
          if (mem_err)     w_state_next = S_ERR;
          else if (w_last) w_state_next = S_CMPL;
        end else if (w_timeout) begin
          w_state_next = S_ERR;
        end
      end
      S_CMPL:  w_state_next = S_DONE;
      S_ERR:   w_state_next = S_DONE;
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Datapath: start capture, beat sequencing, line shifting, error and read result
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_k        <= '0;
      r_line     <= '0;
      r_rx_data  <= '0;
      r_error    <= 1'b0;
      r_mem_req  <= 1'b0;
      r_mem_we   <= 1'b0;
      r_mem_addr <= '0;
    end else begin
      if (w_start) begin
        r_error    <= 1'b0;
        r_k        <= '0;
        r_mem_addr <= w_start_addr;
        r_mem_we   <= w_tx_acc;
        r_mem_req  <= w_aligned;
        r_line     <= {dma_tx_data, {(LINE_W-DATA_W){1'b0}}};
      end
      if (w_beat) begin
        r_k        <= r_k + 1'b1;
        r_mem_addr <= r_mem_addr + 32'd4;
        r_line     <= r_mem_we ? (r_line << 32) : {r_line[LINE_W-33:0], mem_rdata};
        if (mem_err || w_last) r_mem_req <= 1'b0;
      end
      if (w_timeout) r_mem_req <= 1'b0;
      if (r_state == S_CMPL && !r_mem_we) r_rx_data <= r_line[LINE_W-1 -: DATA_W];
      if (w_state_next == S_ERR) r_error <= 1'b1;
    end
  end

  assign dma_rx_data = r_rx_data;
  assign dma_done    = (r_state == S_DONE);
  assign dma_idle    = (r_state == S_IDLE);
  assign dma_error   = r_error;
  assign mem_req     = r_mem_req;
  assign mem_we      = r_mem_we;
  assign mem_addr    = r_mem_addr;
  assign mem_wdata   = r_mem_we ? r_line[LINE_W-1 -: 32] : '0;

endmodule
